// File: rtl/vm_pkg.sv
// Shared vending-machine types: coin codes, coin values and dispenser FSM states.
package vm_pkg;

    typedef enum logic [2:0] {
        COIN_10  = 3'd0,
        COIN_20  = 3'd1,
        COIN_50  = 3'd2,
        COIN_100 = 3'd3,
        COIN_200 = 3'd4
    } coin_e;

    localparam int unsigned NUM_COINS = 5;

    localparam logic [7:0] COIN_VAL_10  = 8'd10;
    localparam logic [7:0] COIN_VAL_20  = 8'd20;
    localparam logic [7:0] COIN_VAL_50  = 8'd50;
    localparam logic [7:0] COIN_VAL_100 = 8'd100;
    localparam logic [7:0] COIN_VAL_200 = 8'd200;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StEject,
        StGap,
        StDone
    } disp_state_e;

    function automatic logic [7:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_10:  coin_value = COIN_VAL_10;
            COIN_20:  coin_value = COIN_VAL_20;
            COIN_50:  coin_value = COIN_VAL_50;
            COIN_100: coin_value = COIN_VAL_100;
            COIN_200: coin_value = COIN_VAL_200;
            default:  coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/denom_select.sv
// Combinational greedy picker: largest non-empty denomination not exceeding remaining.
module denom_select
    import vm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] remaining,
    input  logic [4:0]   coin_empty,
    output logic         found,
    output logic [2:0]   code
);

    localparam int CW = (W > 8) ? W : 8;

    // Ascending scan so the last hit is the largest usable coin.
    always_comb begin
        found = 1'b0;
        code  = 3'd0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (!coin_empty[i] && (CW'(remaining) >= CW'(coin_value(3'(i))))) begin
                found = 1'b1;
                code  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Breaks a change amount into coins (greedy) and feeds a hopper over valid/ready.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int W          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] change_in,
    input  logic [4:0]   coin_empty,
    input  logic         eject_ready,
    output logic         eject_valid,
    output logic [2:0]   eject_coin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] short_amount,
    output logic         err_short,
    output logic         err_ovf
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_e   state;
    logic [W-1:0]  remaining;
    logic [W-1:0]  pending;
    logic [GW-1:0] gap_cnt;
    logic          sel_found;
    logic [2:0]    sel_code;
    logic [W:0]    pend_sum;

    assign pend_sum = {1'b0, pending} + {1'b0, change_in};
    assign busy     = (state != StIdle);

    denom_select #(
        .W(W)
    ) u_denom_select (
        .remaining (remaining),
        .coin_empty(coin_empty),
        .found     (sel_found),
        .code      (sel_code)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            remaining    <= '0;
            pending      <= '0;
            gap_cnt      <= '0;
            eject_valid  <= 1'b0;
            eject_coin   <= 3'd0;
            done         <= 1'b0;
            short_amount <= '0;
            err_short    <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Requests arriving mid-payout are queued; IDLE loads pending itself.
            if (state != StIdle && change_in != '0) begin
                if (pend_sum[W]) begin
                    pending <= '1;
                    err_ovf <= 1'b1;
                end else begin
                    pending <= pend_sum[W-1:0];
                end
            end

            unique case (state)
                StIdle: begin
                    if (change_in != '0 || pending != '0) begin
                        remaining <= change_in + pending;
                        pending   <= '0;
                        state     <= StSelect;
                    end
                end
                StSelect: begin
                    if (sel_found) begin
                        eject_coin  <= sel_code;
                        eject_valid <= 1'b1;
                        state       <= StEject;
                    end else begin
                        done         <= 1'b1;
                        short_amount <= remaining;
                        err_short    <= (remaining != '0);
                        state        <= StDone;
                    end
                end
                StEject: begin
                    if (eject_ready) begin
                        remaining   <= remaining - W'(coin_value(eject_coin));
                        eject_valid <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= (GAP_CYCLES > 0) ? StGap : StSelect;
                    end
                end
                StGap: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= StSelect;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
